// File: rtl/cpu_sequencer.sv
// Control sequencer for the 16-bit datapath: owns the PC, decodes the opcode into
// datapath strobes, stretches LW/SW over a req/ack handshake, and runs, single-steps or halts.
module cpu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic [15:0]      instr,
  input  logic             alu_zero,
  input  logic             mem_ack,
  output logic [15:0]      pc,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       alu_op,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEM, S_PAUSE, S_HALTED
  } state_t;

  localparam logic [1:0] OP_R   = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_BEQ = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  state_t      state;
  logic        mem_is_lw;
  logic [1:0]  op;
  logic        is_halt;
  logic        is_mem_op;
  logic [15:0] pc_inc;
  logic [15:0] br_tgt;
  logic        retire_now;
  logic [15:0] pc_ret;

  assign op        = instr[15:14];
  assign is_halt   = (instr == 16'hFFFF);
  assign is_mem_op = (op == OP_LW) || (op == OP_SW);
  assign pc_inc    = pc + 16'd1;
  assign br_tgt    = pc_inc + {{8{instr[7]}}, instr[7:0]};

  // Retirement happens either straight out of EXEC (R, BEQ) or on the ack cycle of MEM.
  always_comb begin
    retire_now = 1'b0;
    pc_ret     = pc_inc;
    if (state == S_EXEC && !is_halt && !is_mem_op) begin
      retire_now = 1'b1;
      if (op == OP_BEQ && alu_zero) pc_ret = br_tgt;
    end
    if (state == S_MEM && mem_ack) retire_now = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      retired   <= '0;
      mem_is_lw <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            retired <= '0;
          end
        end
        S_FETCH: state <= S_EXEC;
        S_EXEC: begin
          if (is_halt) begin
            state <= S_HALTED;
          end else if (is_mem_op) begin
            state     <= S_MEM;
            mem_is_lw <= (op == OP_LW);
          end
        end
        S_MEM: ;
        S_PAUSE: begin
          if (step || !step_mode) state <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
      if (retire_now) begin
        pc      <= pc_ret;
        retired <= retired + CNT_W'(1);
        state   <= step_mode ? S_PAUSE : S_FETCH;
      end
    end
  end

  // The opcode is latched on entry to MEM so the request stays stable even if instr moves.
  always_comb begin
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_op     = ALU_ADD;
    case (state)
      S_EXEC: begin
        if (!is_halt) begin
          case (op)
            OP_R: begin
              reg_dst   = 1'b1;
              reg_write = 1'b1;
              alu_op    = ALU_FUNCT;
            end
            OP_LW: begin
              alu_src  = 1'b1;
              mem_read = 1'b1;
            end
            OP_SW: begin
              alu_src   = 1'b1;
              mem_write = 1'b1;
            end
            default: alu_op = ALU_SUB;
          endcase
        end
      end
      S_MEM: begin
        alu_src   = 1'b1;
        mem_read  = mem_is_lw;
        mem_write = !mem_is_lw;
        if (mem_ack && mem_is_lw) begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy   = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEM);
  assign halted = (state == S_HALTED);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: instruction-level reference model (PC, retire count, strobe table)
// driven by directed sequences and randomized instruction streams.
module tb_cpu_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        alu_zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic [15:0] pc;
  logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write;
  logic [1:0]  alu_op;
  logic        busy, halted;
  logic [15:0] retired;
  logic [7:0]  strb;

  int checks = 0;
  int failures = 0;
  logic [15:0] pc_m = 16'h0000;
  logic [15:0] ret_m = 16'h0000;

  cpu_sequencer #(.RESET_PC(16'h0000), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step(step),
    .instr(instr), .alu_zero(alu_zero), .mem_ack(mem_ack), .pc(pc),
    .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op),
    .busy(busy), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;
  assign strb = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, alu_op};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Strobe table {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, alu_op}
  function automatic logic [7:0] exp_strb(input logic [15:0] ins, input bit in_mem, input bit ack);
    bit rd = 0, as = 0, m2r = 0, rw = 0, mr = 0, mw = 0;
    logic [1:0] ao = 2'b00;
    if (ins != 16'hFFFF) begin
      case (ins[15:14])
        2'b00: begin rd = 1; rw = 1; ao = 2'b10; end
        2'b01: begin as = 1; mr = 1; if (in_mem && ack) begin rw = 1; m2r = 1; end end
        2'b10: begin as = 1; mw = 1; end
        default: ao = 2'b01;
      endcase
    end
    return {rd, as, m2r, rw, mr, mw, ao};
  endfunction

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    pc_m  = 16'h0000;
    ret_m = 16'h0000;
  endtask

  // Entered in the FETCH cycle; dly = MEM cycles up to and including the ack.
  task automatic run_instr(input logic [15:0] ins, input bit z, input int dly, input bit sm);
    logic [15:0] pc0;
    bit halt;
    bit memop;
    int off;
    pc0   = pc_m;
    halt  = (ins == 16'hFFFF);
    memop = !halt && (ins[15:14] == 2'b01 || ins[15:14] == 2'b10);
    instr = ins; alu_zero = z; step_mode = sm;
    mem_ack = 1'($urandom % 2); step = 1'($urandom % 2); start = 1'($urandom % 2);
    #1;
    chk("fetch_state", 32'({busy, halted}), 32'b10);
    chk("fetch_strb", 32'(strb), 32'h0);
    chk("fetch_pc", 32'(pc), 32'(pc_m));
    tick;
    mem_ack = 1'($urandom % 2); step = 1'($urandom % 2); start = 1'($urandom % 2);
    #1;
    chk("exec_strb", 32'(strb), 32'(exp_strb(ins, 1'b0, 1'b0)));
    chk("exec_busy", 32'(busy), 32'h1);
    if (memop) begin
      for (int k = 0; k < dly; k++) begin
        tick;
        mem_ack = (k == dly - 1);
        step = 1'($urandom % 2); start = 1'($urandom % 2);
        #1;
        chk("mem_strb", 32'(strb), 32'(exp_strb(ins, 1'b1, mem_ack)));
        chk("mem_pc", 32'(pc), 32'(pc0));
      end
    end
    if (!halt) begin
      off = ins[7] ? int'(ins[7:0]) - 256 : int'(ins[7:0]);
      if (ins[15:14] == 2'b11 && z) pc_m = 16'(int'(pc_m) + 1 + off);
      else pc_m = 16'(int'(pc_m) + 1);
      ret_m = ret_m + 16'd1;
    end
    tick;
    mem_ack = 1'b0; step = 1'b0; start = 1'b0;
    #1;
    if (halt) chk("halt_state", 32'({busy, halted}), 32'b01);
    else chk("post_state", 32'({busy, halted}), sm ? 32'b00 : 32'b10);
    chk("post_strb", 32'(strb), 32'h0);
    chk("pc", 32'(pc), 32'(pc_m));
    chk("retired", 32'(retired), 32'(ret_m));
  endtask

  // Entered in PAUSE; stays paused against start/ack, then leaves via step or step_mode drop.
  task automatic do_step(input bit use_drop);
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; mem_ack = 1'b1; step = 1'b0;
      #1;
      chk("pause_state", 32'({busy, halted}), 32'b00);
      chk("pause_pc", 32'(pc), 32'(pc_m));
      chk("pause_strb", 32'(strb), 32'h0);
      tick;
    end
    start = 1'b0; mem_ack = 1'b0;
    if (use_drop) step_mode = 1'b0;
    else step = 1'b1;
    tick;
    step = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ins;
    bit sm;
    // Reset with start held: must stay idle
    rst_n = 1'b0; start = 1'b1;
    repeat (2) tick;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_retired", 32'(retired), 32'h0);
    chk("rst_state", 32'({busy, halted}), 32'b00);
    chk("rst_strb", 32'(strb), 32'h0);
    start = 1'b0; rst_n = 1'b1;
    tick;
    chk("idle_hold", 32'({busy, halted}), 32'b00);

    do_start;
    run_instr(16'h0000, 1'b0, 1, 1'b0);
    run_instr(16'h4105, 1'b0, 3, 1'b0);
    repeat (3) run_instr(16'h0000, 1'b0, 1, 1'b0);
    chk("pc_at5", 32'(pc), 32'h5);
    run_instr(16'hC0FE, 1'b1, 1, 1'b0);
    run_instr(16'h0000, 1'b0, 1, 1'b0);
    run_instr(16'hC0FE, 1'b0, 1, 1'b0);
    run_instr(16'hFFFF, 1'b1, 1, 1'b0);
    repeat (2) begin
      tick;
      chk("halt_frozen", 32'(pc), 32'(pc_m));
    end
    do_start;
    run_instr(16'hC0FE, 1'b1, 1, 1'b0);
    chk("pc_wrap_lo", 32'(pc), 32'hFFFF);
    run_instr(16'hC0FE, 1'b0, 1, 1'b0);
    chk("pc_wrap_hi", 32'(pc), 32'h0);
    run_instr(16'h0000, 1'b0, 1, 1'b1);
    do_step(1'b0);
    run_instr(16'h8000, 1'b0, 2, 1'b1);
    do_step(1'b1);

    // Reset while a SW request is outstanding
    instr = 16'h8000; mem_ack = 1'b0;
    tick;
    tick;
    chk("mid_mem_req", 32'(mem_write), 32'h1);
    rst_n = 1'b0;
    tick;
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_mem_state", 32'({busy, halted}), 32'b00);
    chk("rst_mem_pc", 32'(pc), 32'h0);
    rst_n = 1'b1;
    tick;
    do_start;

    for (int i = 0; i < 300; i++) begin
      ins = 16'($urandom);
      if ($urandom % 10 == 0) ins = 16'hFFFF;
      else if (ins == 16'hFFFF) ins = 16'h0000;
      sm = ($urandom % 4 == 0);
      run_instr(ins, 1'($urandom % 2), 1 + int'($urandom % 4), sm);
      if (ins == 16'hFFFF) do_start;
      else if (sm) do_step(1'($urandom % 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
